// File: rtl/sqrt_regime_unit_pkg.sv
// Shared codes for the square-root regime unit: FSM states, regime requests, status bit positions.
package sqrt_regime_unit_pkg;

   typedef enum logic [3:0] {
      ST_OFF    = 4'd0,
      ST_IDLE   = 4'd1,
      ST_LOAD   = 4'd2,
      ST_CALC   = 4'd3,
      ST_DONE   = 4'd4,
      ST_T_LOAD = 4'd5,
      ST_T_CALC = 4'd6,
      ST_T_CHK  = 4'd7
   } state_t;

   localparam logic [1:0] REG_OFF    = 2'd0;
   localparam logic [1:0] REG_SINGLE = 2'd1;
   localparam logic [1:0] REG_AUTO   = 2'd2;
   localparam logic [1:0] REG_TEST   = 2'd3;

   localparam int S_DONE  = 0;
   localparam int S_ERR   = 1;
   localparam int S_SWEEP = 2;

endpackage

// File: rtl/sqrt_regime_unit_core.sv
// Restoring integer square-root datapath: one root bit per step, W/2 steps per operand.
module isqrt_core #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   x,
   output logic [W/2-1:0] root,
   output logic [W/2-1:0] root_step,
   output logic           last
);
   localparam int RW   = W / 2;
   localparam int ITER = W / 2;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

   logic [W-1:0]    op_reg;
   logic [RW+1:0]   rem_reg;
   logic [RW-1:0]   root_reg;
   logic [CW-1:0]   cnt_reg;
   logic [RW+1:0]   rem_shift;
   logic [RW+1:0]   trial;
   logic [RW+1:0]   rem_step;

   // The partial remainder never exceeds 2*root, so its top two bits are free to drop on the shift.
   always_comb begin
      rem_shift = {rem_reg[RW-1:0], op_reg[W-1 -: 2]};
      trial     = {root_reg, 2'b01};
      rem_step  = rem_shift;
      root_step = {root_reg[RW-2:0], 1'b0};
      if (rem_shift >= trial) begin
         rem_step  = rem_shift - trial;
         root_step = {root_reg[RW-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg   <= '0;
         rem_reg  <= '0;
         root_reg <= '0;
         cnt_reg  <= '0;
      end else if (load) begin
         op_reg   <= x;
         rem_reg  <= '0;
         root_reg <= '0;
         cnt_reg  <= CW'(ITER - 1);
      end else if (step) begin
         op_reg   <= {op_reg[W-3:0], 2'b00};
         rem_reg  <= rem_step;
         root_reg <= root_step;
         cnt_reg  <= cnt_reg - 1'b1;
      end
   end

   assign root = root_reg;
   assign last = (cnt_reg == '0);

endmodule

// File: rtl/sqrt_regime_unit.sv
// Regime-switched square-root engine: FSM, regime latch, start edge detector and self-test sweep.
module sqrt_regime_unit
   import sqrt_regime_unit_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] x,
   input  logic [1:0]   on,
   input  logic         start,
   output logic [W-1:0] y,
   output logic [2:0]   s,
   output logic         b,
   output logic         active,
   output logic [1:0]   regime,
   output logic [3:0]   real_state
);
   state_t          state_reg;
   logic [1:0]      regime_reg;
   logic            start_q;
   logic [W-1:0]    y_reg;
   logic [2:0]      s_reg;
   logic [W-1:0]    t_reg;

   logic            core_load;
   logic            core_step;
   logic [W-1:0]    core_x;
   logic [W/2-1:0]  core_root;
   logic [W/2-1:0]  core_root_step;
   logic            core_last;

   logic [W+1:0]    chk_t;
   logic [W+1:0]    chk_r;
   logic [W+1:0]    chk_r1;
   logic            chk_ok;

   assign core_load = (state_reg == ST_LOAD) || (state_reg == ST_T_LOAD);
   assign core_step = (state_reg == ST_CALC) || (state_reg == ST_T_CALC);
   assign core_x    = (state_reg == ST_T_LOAD) ? t_reg : x;

   isqrt_core #(.W(W)) u_core (
      .clk       (clk),
      .rst       (rst),
      .load      (core_load),
      .step      (core_step),
      .x         (core_x),
      .root      (core_root),
      .root_step (core_root_step),
      .last      (core_last)
   );

   // Widened so (r+1)^2 cannot overflow when r is the largest W/2-bit root.
   always_comb begin
      chk_t  = (W+2)'(t_reg);
      chk_r  = (W+2)'(core_root);
      chk_r1 = chk_r + 1'b1;
      chk_ok = ((chk_r * chk_r) <= chk_t) && (chk_t < (chk_r1 * chk_r1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_OFF;
         regime_reg <= REG_OFF;
         start_q    <= 1'b0;
         y_reg      <= '0;
         s_reg      <= '0;
         t_reg      <= '0;
      end else begin
         start_q        <= start;
         s_reg[S_DONE]  <= 1'b0;
         if (state_reg inside {ST_OFF, ST_IDLE, ST_DONE})
            regime_reg <= on;
         if (on == REG_OFF) begin
            state_reg <= ST_OFF;
         end else begin
            case (state_reg)
               ST_OFF:  state_reg <= ST_IDLE;
               ST_IDLE: begin
                  case (on)
                     REG_SINGLE: if (start && !start_q) state_reg <= ST_LOAD;
                     REG_AUTO:   state_reg <= ST_LOAD;
                     REG_TEST: begin
                        // Every IDLE->T_LOAD entry begins a fresh sweep; TEST loops stay out of IDLE.
                        state_reg          <= ST_T_LOAD;
                        s_reg[S_SWEEP:S_ERR] <= 2'b00;
                        t_reg              <= '0;
                     end
                     default: ;
                  endcase
               end
               ST_LOAD: state_reg <= ST_CALC;
               ST_CALC: begin
                  if (core_last) begin
                     state_reg     <= ST_DONE;
                     y_reg         <= W'(core_root_step);
                     s_reg[S_DONE] <= 1'b1;
                  end
               end
               ST_DONE:   state_reg <= ST_IDLE;
               ST_T_LOAD: state_reg <= ST_T_CALC;
               ST_T_CALC: if (core_last) state_reg <= ST_T_CHK;
               ST_T_CHK: begin
                  y_reg         <= W'(core_root);
                  s_reg[S_DONE] <= 1'b1;
                  if (!chk_ok) s_reg[S_ERR] <= 1'b1;
                  if (&t_reg) s_reg[S_SWEEP] <= 1'b1;
                  t_reg         <= t_reg + 1'b1;
                  state_reg     <= (on == REG_TEST) ? ST_T_LOAD : ST_IDLE;
               end
               default: state_reg <= ST_OFF;
            endcase
         end
      end
   end

   assign y          = y_reg;
   assign s          = s_reg;
   assign b          = state_reg inside {ST_LOAD, ST_CALC, ST_T_LOAD, ST_T_CALC, ST_T_CHK};
   assign active     = (regime_reg != REG_OFF) && (state_reg != ST_OFF);
   assign regime     = regime_reg;
   assign real_state = state_reg;

endmodule

// File: tb/tb_sqrt_regime_unit.sv
// Directed bench for sqrt_regime_unit (W=8): reset, SINGLE latency, held start, AUTO, TEST sweep, abort.
module tb_sqrt_regime_unit;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] x;
   logic [1:0]   on;
   logic         start;
   logic [W-1:0] y;
   logic [2:0]   s;
   logic         b;
   logic         active;
   logic [1:0]   regime;
   logic [3:0]   real_state;

   int checks = 0;
   int errors = 0;

   sqrt_regime_unit #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .x          (x),
      .on         (on),
      .start      (start),
      .y          (y),
      .s          (s),
      .b          (b),
      .active     (active),
      .regime     (regime),
      .real_state (real_state)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; on = 2'd2; x = 8'd5; start = 1'b0;
      repeat (4) tick();
      checks++; if (y !== 8'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", y); end
      checks++; if (s !== 3'd0) begin errors++; $display("FAIL reset_s got=%b exp=000", s); end
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL reset_b got=%b exp=0", b); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
      checks++; if (regime !== 2'd0) begin errors++; $display("FAIL reset_regime got=%0d exp=0", regime); end
      checks++; if (real_state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", real_state); end
      rst = 1'b0; on = 2'd0;
      repeat (3) tick();
      checks++; if (real_state !== 4'd0) begin errors++; $display("FAIL off_hold_state got=%0d exp=0", real_state); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL off_hold_active got=%b exp=0", active); end
      $display("reset: y=%0d s=%b state=%0d", y, s, real_state);
   endtask

   task automatic test_single_latency;
      logic [3:0] exp_st [7];
      logic       exp_b  [7];
      logic       exp_d  [7];
      exp_st = '{4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd1};
      exp_b  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_d  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      on = 2'd1; x = 8'd5;
      tick();
      checks++; if (real_state !== 4'd1) begin errors++; $display("FAIL single_idle got=%0d exp=1", real_state); end
      checks++; if (regime !== 2'd1) begin errors++; $display("FAIL single_regime got=%0d exp=1", regime); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active got=%b exp=1", active); end
      start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         start = 1'b0;
         checks++; if (real_state !== exp_st[i]) begin errors++; $display("FAIL lat_state[%0d] got=%0d exp=%0d", i, real_state, exp_st[i]); end
         checks++; if (b !== exp_b[i]) begin errors++; $display("FAIL lat_busy[%0d] got=%b exp=%b", i, b, exp_b[i]); end
         checks++; if (s[0] !== exp_d[i]) begin errors++; $display("FAIL lat_done[%0d] got=%b exp=%b", i, s[0], exp_d[i]); end
         if (i == 5) begin
            checks++; if (y !== 8'd2) begin errors++; $display("FAIL lat_y got=%0d exp=2", y); end
         end
      end
      $display("single: x=5 y=%0d", y);
   endtask

   task automatic run_held(input logic [W-1:0] xv, input logic [W-1:0] yexp);
      int pulses;
      logic [W-1:0] ycap;
      pulses = 0; ycap = 'x;
      x = xv; start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s[0] === 1'b1) begin pulses++; ycap = y; end
      end
      start = 1'b0;
      repeat (2) tick();
      checks++; if (pulses != 1) begin errors++; $display("FAIL held_pulses x=%0d got=%0d exp=1", xv, pulses); end
      checks++; if (ycap !== yexp) begin errors++; $display("FAIL held_y x=%0d got=%0d exp=%0d", xv, ycap, yexp); end
      $display("held: x=%0d y=%0d pulses=%0d", xv, ycap, pulses);
   endtask

   task automatic test_start_held;
      run_held(8'd255, 8'd15);
      run_held(8'd0, 8'd0);
   endtask

   task automatic test_auto;
      int n;
      on = 2'd2; x = 8'd144;
      repeat (3) tick();
      x = 8'd200;
      n = 0;
      while (s[0] !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (s[0] !== 1'b1) begin errors++; $display("FAIL auto_first_timeout got=%b exp=1", s[0]); end
      checks++; if (y !== 8'd12) begin errors++; $display("FAIL auto_first_y got=%0d exp=12", y); end
      $display("auto: x=144 y=%0d", y);
      n = 0;
      do begin tick(); n++; end while (s[0] !== 1'b1 && n < 20);
      checks++; if (n != 7) begin errors++; $display("FAIL auto_period got=%0d exp=7", n); end
      checks++; if (y !== 8'd14) begin errors++; $display("FAIL auto_second_y got=%0d exp=14", y); end
      $display("auto: x=200 y=%0d period=%0d", y, n);
      on = 2'd0;
      tick();
      checks++; if (real_state !== 4'd0) begin errors++; $display("FAIL auto_off_state got=%0d exp=0", real_state); end
      checks++; if (y !== 8'd14) begin errors++; $display("FAIL auto_off_y got=%0d exp=14", y); end
   endtask

   task automatic test_sweep;
      int n;
      on = 2'd3;
      n = 0;
      while (s[2] !== 1'b1 && n < 256*7+10) begin tick(); n++; end
      checks++; if (s[2] !== 1'b1) begin errors++; $display("FAIL sweep_complete got=%b exp=1", s[2]); end
      checks++; if (y !== 8'd15) begin errors++; $display("FAIL sweep_last_y got=%0d exp=15", y); end
      checks++; if (s[1] !== 1'b0) begin errors++; $display("FAIL sweep_err got=%b exp=0", s[1]); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL sweep_busy got=%b exp=1", b); end
      $display("sweep: cycles=%0d y=%0d s=%b", n, y, s);
      force dut.core_root = '0;
      repeat (20) tick();
      checks++; if (s[1] !== 1'b1) begin errors++; $display("FAIL fault_err got=%b exp=1", s[1]); end
      release dut.core_root;
      on = 2'd0;
      tick();
      checks++; if (s[2:1] !== 2'b11) begin errors++; $display("FAIL sticky_off got=%b exp=11", s[2:1]); end
      checks++; if (real_state !== 4'd0) begin errors++; $display("FAIL sweep_off_state got=%0d exp=0", real_state); end
      $display("fault: s=%b", s);
   endtask

   task automatic test_abort_reset;
      int n;
      int pulses;
      on = 2'd1; x = 8'd9; start = 1'b0;
      tick();
      start = 1'b1;
      n = 0;
      do begin tick(); n++; end while (s[0] !== 1'b1 && n < 20);
      start = 1'b0;
      checks++; if (y !== 8'd3) begin errors++; $display("FAIL abort_pre_y got=%0d exp=3", y); end
      repeat (2) tick();
      x = 8'd255; start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      checks++; if (real_state !== 4'd3) begin errors++; $display("FAIL abort_calc got=%0d exp=3", real_state); end
      on = 2'd0;
      tick();
      checks++; if (real_state !== 4'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", real_state); end
      checks++; if (y !== 8'd3) begin errors++; $display("FAIL abort_y got=%0d exp=3", y); end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (s[0] === 1'b1) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL abort_pulse got=%0d exp=0", pulses); end
      $display("abort: y=%0d state=%0d", y, real_state);
      on = 2'd1;
      tick();
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (real_state !== 4'd0) begin errors++; $display("FAIL rst_calc_state got=%0d exp=0", real_state); end
      checks++; if (y !== 8'd0) begin errors++; $display("FAIL rst_calc_y got=%0d exp=0", y); end
      checks++; if (s !== 3'd0) begin errors++; $display("FAIL rst_calc_s got=%b exp=000", s); end
      checks++; if (regime !== 2'd0) begin errors++; $display("FAIL rst_calc_regime got=%0d exp=0", regime); end
      checks++; if ({b, active} !== 2'b00) begin errors++; $display("FAIL rst_calc_b_active got=%b exp=00", {b, active}); end
      tick();
      rst = 1'b0;
      $display("mid-calc reset: y=%0d s=%b state=%0d", y, s, real_state);
   endtask

   initial begin
      test_reset();
      test_single_latency();
      test_start_held();
      test_auto();
      test_sweep();
      test_abort_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
